// File: rtl/mem_stage_pkg.sv
// Shared widths, mem_op codes and the Execute->Memory field bundle
// for the memory-access stage.
package mem_stage_pkg;

    localparam int EM_BUS_W    = 194;
    localparam int MW_BUS_W    = 191;
    localparam int CSR2TLB_W   = 43;
    localparam int EM_FIELDS_W = 164;
    localparam int MFWD_W      = 39;

    localparam logic [2:0] OP_LDW  = 3'd0;
    localparam logic [2:0] OP_LDB  = 3'd1;
    localparam logic [2:0] OP_LDH  = 3'd2;
    localparam logic [2:0] OP_LDBU = 3'd4;
    localparam logic [2:0] OP_LDHU = 3'd5;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic        gr_we;
        logic [4:0]  dest;
        logic        mem_re;
        logic [2:0]  mem_op;
        logic        req_issued;
        logic        ex;
        logic [7:0]  ecode;
        logic        esubcode;
        logic [13:0] csr_addr;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic [31:0] csr_wdata;
    } em_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: byte/half select by address and sign/zero
// extension by mem_op.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  mem_op,
    output logic [31:0] result
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr, 3'b000};

    always_comb begin
        result = shifted;
        case (mem_op)
            OP_LDB:  result = {{24{shifted[7]}}, shifted[7:0]};
            OP_LDH:  result = {{16{shifted[15]}}, shifted[15:0]};
            OP_LDBU: result = {24'd0, shifted[7:0]};
            OP_LDHU: result = {16'd0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for data-SRAM responses, buffers
// them under backpressure and drops responses of squashed loads.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int MW_BUS_Wid         = MW_BUS_W,
    parameter int EM_BUS_Wid         = EM_BUS_W,
    parameter int CSR2TLB_BUS_MW_Wid = CSR2TLB_W
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          M_allowin,
    input  logic                          EM_valid,
    input  logic [EM_BUS_Wid-1:0]         EM_BUS,
    input  logic [CSR2TLB_BUS_MW_Wid-1:0] CSR2TLB_BUS_E,
    input  logic                          W_allowin,
    output logic                          MW_valid,
    output logic [MW_BUS_Wid-1:0]         MW_BUS,
    output logic [CSR2TLB_BUS_MW_Wid-1:0] CSR2TLB_BUS_M,
    input  logic                          data_sram_data_ok,
    input  logic [31:0]                   data_sram_rdata,
    input  logic                          ex_en,
    output logic [MFWD_W-1:0]             Mfwd_BUS
);

    em_t                           em_in;
    em_t                           em_q, em_d;
    logic [CSR2TLB_BUS_MW_Wid-1:0] tlb_q, tlb_d;
    logic                          m_valid_q, m_valid_d;
    logic                          buf_valid_q, buf_valid_d;
    logic [31:0]                   rbuf_q, rbuf_d;
    logic [1:0]                    discard_cnt_q, discard_cnt_d;

    logic        need_resp;
    logic        resp_hit;
    logic        ready_go;
    logic        mw_fire;
    logic [1:0]  inc;
    logic        dec;
    logic [2:0]  cnt_sum;
    logic [31:0] rdata_sel;
    logic [31:0] extracted;
    logic [31:0] final_result;
    logic        unused_em_hi;

    assign em_in        = em_t'(EM_BUS[EM_FIELDS_W-1:0]);
    assign unused_em_hi = ^EM_BUS[EM_BUS_Wid-1:EM_FIELDS_W];

    assign need_resp = m_valid_q && em_q.req_issued && !em_q.ex;
    assign resp_hit  = data_sram_data_ok && (discard_cnt_q == 2'd0);
    assign ready_go  = !need_resp || resp_hit || buf_valid_q;
    assign MW_valid  = m_valid_q && ready_go && !ex_en;
    assign M_allowin = !m_valid_q || (ready_go && W_allowin);
    assign mw_fire   = MW_valid && W_allowin;

    assign rdata_sel = buf_valid_q ? rbuf_q : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .rdata  (rdata_sel),
        .addr   (em_q.alu_result[1:0]),
        .mem_op (em_q.mem_op),
        .result (extracted)
    );

    assign final_result = em_q.mem_re ? extracted : em_q.alu_result;

    // Squashed requests still owe a response; count them so the
    // memory side's late data_ok strobes are swallowed.
    always_comb begin
        inc = 2'd0;
        if (ex_en) begin
            inc = {1'b0, need_resp && !resp_hit && !buf_valid_q}
                + {1'b0, EM_valid && em_in.req_issued};
        end
    end

    assign dec     = data_sram_data_ok && (discard_cnt_q != 2'd0);
    assign cnt_sum = {1'b0, discard_cnt_q} + {1'b0, inc} - {2'b00, dec};

    always_comb begin
        em_d          = em_q;
        tlb_d         = tlb_q;
        m_valid_d     = m_valid_q;
        buf_valid_d   = buf_valid_q;
        rbuf_d        = rbuf_q;
        discard_cnt_d = (cnt_sum > 3'd2) ? 2'd2 : cnt_sum[1:0];

        if (EM_valid && M_allowin) begin
            em_d  = em_in;
            tlb_d = CSR2TLB_BUS_E;
        end

        if (ex_en) begin
            m_valid_d = 1'b0;
        end else if (M_allowin) begin
            m_valid_d = EM_valid;
        end

        if (ex_en || mw_fire) begin
            buf_valid_d = 1'b0;
        end else if (need_resp && resp_hit && !buf_valid_q) begin
            buf_valid_d = 1'b1;
            rbuf_d      = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            em_q          <= '0;
            tlb_q         <= '0;
            m_valid_q     <= 1'b0;
            buf_valid_q   <= 1'b0;
            rbuf_q        <= '0;
            discard_cnt_q <= 2'd0;
        end else begin
            em_q          <= em_d;
            tlb_q         <= tlb_d;
            m_valid_q     <= m_valid_d;
            buf_valid_q   <= buf_valid_d;
            rbuf_q        <= rbuf_d;
            discard_cnt_q <= discard_cnt_d;
        end
    end

    assign MW_BUS = {
        em_q.pc, final_result, em_q.gr_we, em_q.dest, em_q.alu_result,
        em_q.ex, em_q.ecode, em_q.esubcode, em_q.csr_addr, em_q.csr_we,
        em_q.csr_wmask, em_q.csr_wdata
    };

    assign CSR2TLB_BUS_M = tlb_q;

    assign Mfwd_BUS = {
        m_valid_q && em_q.gr_we,
        em_q.dest,
        final_result,
        m_valid_q && em_q.mem_re && !ready_go
    };

endmodule
